fsm_in_debounce: RTL and testbench

Input conditioner that sits directly upstream of the 5-state sequence FSM and drives its 2-bit `in` port. Raw 2-bit inputs from switches or pins are asynchronous and noisy. This block synchronises them, requires a new code to be stable for a programmable number of cycles, and only then commits it to `out_sym`. It also counts rejected glitches for bring-up debug.

---
 rtl/fsm_in_pkg.sv | 12 +
 rtl/fsm_in_debounce_if.sv | 25 ++
 rtl/fsm_in_debounce_sync_2ff.sv | 28 ++
 rtl/fsm_in_debounce.sv | 125 ++++++++++++
 tb/tb_fsm_in_debounce.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fsm_in_pkg.sv
// Shared definitions for the sequence-FSM input conditioner: symbol width
// and settle-FSM state encodings.
package fsm_in_pkg;

    localparam int SYM_W = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

endpackage

// File: rtl/fsm_in_debounce_if.sv
// Symbol-side bundle of the input conditioner: raw input and glitch clear in,
// committed symbol, strobe, busy flag and glitch count out.
interface fsm_in_debounce_if #(
    parameter int GLITCH_W = 8
);
    import fsm_in_pkg::*;

    logic [SYM_W-1:0]    raw_in;
    logic                clr_glitch;
    logic [SYM_W-1:0]    out_sym;
    logic                sym_valid;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output raw_in, clr_glitch,
        input  out_sym, sym_valid, busy, glitch_cnt
    );

    modport slave (
        input  raw_in, clr_glitch,
        output out_sym, sym_valid, busy, glitch_cnt
    );

endinterface

// File: rtl/fsm_in_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; both stages clear on
// an active-low asynchronous reset.
module sync_2ff #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_r;
    logic [W-1:0] s2_r;

    // metastability chain: s1 may go metastable, s2 is the clean copy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= {W{1'b0}};
            s2_r <= {W{1'b0}};
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/fsm_in_debounce.sv
// Debounces a 2-bit raw symbol: a new code must hold DEBOUNCE_CYCLES
// synchronised samples before it is committed to out_sym.
module fsm_in_debounce
    import fsm_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int GLITCH_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    fsm_in_debounce_if.slave      bus
);

    localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = {{(GLITCH_W-1){1'b0}}, 1'b1};

    logic [SYM_W-1:0]    s2_s;
    state_e              state_r, state_s;
    logic [SYM_W-1:0]    cand_r, cand_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [SYM_W-1:0]    out_sym_r, out_sym_s;
    logic                sym_valid_r, sym_valid_s;
    logic                busy_r;
    logic                glitch_s;
    logic [GLITCH_W-1:0] glitch_cnt_r, glitch_cnt_s;

    sync_2ff #(.W(SYM_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (s2_s)
    );

    // settle FSM: candidate tracking, commit decision and glitch detection
    always_comb begin
        state_s     = state_r;
        cand_s      = cand_r;
        cnt_s       = cnt_r;
        out_sym_s   = out_sym_r;
        sym_valid_s = 1'b0;
        glitch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s2_s != out_sym_r) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        out_sym_s   = s2_s;
                        sym_valid_s = 1'b1;
                    end else begin
                        cand_s  = s2_s;
                        cnt_s   = CNT_ONE;
                        state_s = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (s2_s == cand_r) begin
                    if (cnt_r == CNT_LAST) begin
                        out_sym_s   = cand_r;
                        sym_valid_s = 1'b1;
                        cnt_s       = {CNT_W{1'b0}};
                        state_s     = ST_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else if (s2_s == out_sym_r) begin
                    glitch_s = 1'b1;
                    cnt_s    = {CNT_W{1'b0}};
                    state_s  = ST_IDLE;
                end else begin
                    // a third code restarts the latency count from this edge
                    glitch_s = 1'b1;
                    cand_s   = s2_s;
                    cnt_s    = CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // glitch counter: saturating, clear has priority over a coincident glitch
    always_comb begin
        glitch_cnt_s = glitch_cnt_r;
        if (bus.clr_glitch) begin
            glitch_cnt_s = {GLITCH_W{1'b0}};
        end else if (glitch_s && (glitch_cnt_r != GLITCH_MAX)) begin
            glitch_cnt_s = glitch_cnt_r + GLITCH_ONE;
        end else begin
            glitch_cnt_s = glitch_cnt_r;
        end
    end

    // state, counters and all outputs registered together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cand_r       <= {SYM_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            out_sym_r    <= {SYM_W{1'b0}};
            sym_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            glitch_cnt_r <= {GLITCH_W{1'b0}};
        end else begin
            state_r      <= state_s;
            cand_r       <= cand_s;
            cnt_r        <= cnt_s;
            out_sym_r    <= out_sym_s;
            sym_valid_r  <= sym_valid_s;
            busy_r       <= (state_s == ST_SETTLE);
            glitch_cnt_r <= glitch_cnt_s;
        end
    end

    assign bus.out_sym    = out_sym_r;
    assign bus.sym_valid  = sym_valid_r;
    assign bus.busy       = busy_r;
    assign bus.glitch_cnt = glitch_cnt_r;

endmodule

// File: tb/tb_fsm_in_debounce.sv
// Bench for fsm_in_debounce: DEBOUNCE_CYCLES=4/GLITCH_W=2 and DEBOUNCE_CYCLES=1
// instances; expected commits are queued by the stimulus and checked by a monitor.
module tb_fsm_in_debounce;

    typedef struct {
        logic [1:0] sym;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [1:0] prev_a = 2'b00;
    logic [1:0] prev_b = 2'b00;
    int   c;

    fsm_in_debounce_if #(.GLITCH_W(2)) ifa ();
    fsm_in_debounce_if #(.GLITCH_W(8)) ifb ();

    fsm_in_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .GLITCH_W(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    fsm_in_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(8), .GLITCH_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitors: every sym_valid pops one expected commit; silent changes are errors
    always @(negedge clk) begin
        if (reset) begin
            if (ifa.sym_valid) begin
                chk("a_commit_expected", 32'(qa.size() > 0), 32'd1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("a_commit_sym", 32'(ifa.out_sym), 32'(ea.sym));
                    chk("a_commit_cycle", cyc, ea.cyc);
                end
            end else if (ifa.out_sym !== prev_a) begin
                chk("a_silent_change", 32'(ifa.out_sym), 32'(prev_a));
            end
            if (ifb.sym_valid) begin
                chk("b_commit_expected", 32'(qb.size() > 0), 32'd1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("b_commit_sym", 32'(ifb.out_sym), 32'(eb.sym));
                    chk("b_commit_cycle", cyc, eb.cyc);
                end
            end else if (ifb.out_sym !== prev_b) begin
                chk("b_silent_change", 32'(ifb.out_sym), 32'(prev_b));
            end
        end
        prev_a = ifa.out_sym;
        prev_b = ifb.out_sym;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_exp[3] = '{3, 3, 3};
        reset = 1'b0;
        ifa.raw_in = 2'b11;
        ifa.clr_glitch = 1'b0;
        ifb.raw_in = 2'b00;
        ifb.clr_glitch = 1'b0;
        tick(3);
        chk("rst_out_sym", 32'(ifa.out_sym), 32'd0);
        chk("rst_sym_valid", 32'(ifa.sym_valid), 32'd0);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_glitch", 32'(ifa.glitch_cnt), 32'd0);
        chk("rst_b_out_sym", 32'(ifb.out_sym), 32'd0);

        // release with 11 held: commit at 6th edge
        reset = 1'b1;
        qa.push_back('{2'b11, cyc + 6});
        tick(8);
        chk("rel_out_sym", 32'(ifa.out_sym), 32'd3);

        // 00 -> 10 with busy window
        ifa.raw_in = 2'b00;
        qa.push_back('{2'b00, cyc + 6});
        tick(8);
        c = cyc;
        ifa.raw_in = 2'b10;
        qa.push_back('{2'b10, c + 6});
        tick(2);
        chk("busy_e2", 32'(ifa.busy), 32'd0);
        tick(1);
        chk("busy_e3", 32'(ifa.busy), 32'd1);
        tick(2);
        chk("busy_e5", 32'(ifa.busy), 32'd1);
        tick(1);
        chk("busy_e6", 32'(ifa.busy), 32'd0);
        chk("out_e6", 32'(ifa.out_sym), 32'd2);
        tick(4);
        chk("glitch_none", 32'(ifa.glitch_cnt), 32'd0);

        // single-cycle pulse back to committed value
        ifa.raw_in = 2'b00;
        qa.push_back('{2'b00, cyc + 6});
        tick(8);
        ifa.raw_in = 2'b01;
        tick(1);
        ifa.raw_in = 2'b00;
        tick(6);
        chk("pulse_glitch", 32'(ifa.glitch_cnt), 32'd1);
        chk("pulse_out", 32'(ifa.out_sym), 32'd0);
        chk("pulse_busy", 32'(ifa.busy), 32'd0);

        // 01 for two cycles then 10: candidate replaced, commit at E8
        c = cyc;
        ifa.raw_in = 2'b01;
        qa.push_back('{2'b10, c + 8});
        tick(2);
        ifa.raw_in = 2'b10;
        tick(9);
        chk("repl_glitch", 32'(ifa.glitch_cnt), 32'd2);
        chk("repl_out", 32'(ifa.out_sym), 32'd2);

        // three more isolated glitches: 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            ifa.raw_in = 2'b01;
            tick(1);
            ifa.raw_in = 2'b10;
            tick(6);
            chk("sat_glitch", 32'(ifa.glitch_cnt), 32'(sat_exp[i]));
        end

        // clear coincides with sixth glitch (detected at E4)
        ifa.raw_in = 2'b01;
        tick(1);
        ifa.raw_in = 2'b10;
        tick(2);
        ifa.clr_glitch = 1'b1;
        tick(1);
        ifa.clr_glitch = 1'b0;
        chk("clr_wins", 32'(ifa.glitch_cnt), 32'd0);
        tick(3);
        chk("clr_hold", 32'(ifa.glitch_cnt), 32'd0);

        // asynchronous reset mid-settle of 00 -> 11
        ifa.raw_in = 2'b00;
        qa.push_back('{2'b00, cyc + 6});
        tick(8);
        ifa.raw_in = 2'b11;
        tick(3);
        chk("mid_busy_before", 32'(ifa.busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_busy_async", 32'(ifa.busy), 32'd0);
        chk("mid_out_async", 32'(ifa.out_sym), 32'd0);
        chk("mid_valid_async", 32'(ifa.sym_valid), 32'd0);
        tick(2);
        reset = 1'b1;
        qa.push_back('{2'b11, cyc + 6});
        tick(8);
        chk("mid_out_after", 32'(ifa.out_sym), 32'd3);

        // DEBOUNCE_CYCLES=1: commit at E3, back-to-back commits
        c = cyc;
        ifb.raw_in = 2'b01;
        qb.push_back('{2'b01, c + 3});
        tick(2);
        chk("b_busy", 32'(ifb.busy), 32'd0);
        tick(3);
        c = cyc;
        ifb.raw_in = 2'b10;
        qb.push_back('{2'b10, c + 3});
        tick(1);
        ifb.raw_in = 2'b11;
        qb.push_back('{2'b11, c + 4});
        tick(6);
        chk("b_out_final", 32'(ifb.out_sym), 32'd3);
        chk("b_glitch", 32'(ifb.glitch_cnt), 32'd0);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
